// File: rtl/mul_arb_pkg.sv
// Shared definitions for the shared-multiplier arbiter: slot states and the
// operand/product widths of the 8x8 signed multiplier.
package mul_arb_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        SLOT_EMPTY    = 2'd0,
        SLOT_INFLIGHT = 2'd1,
        SLOT_FULL     = 2'd2
    } slot_state_e;

endpackage

// File: rtl/mul_arb_rr.sv
// Combinational round-robin picker. i_ptr names the requester holding top
// priority; the search walks upward from it and wraps. o_ptr_nxt is the index
// after the winner, or i_ptr unchanged when nothing is eligible.
module mul_arb_rr #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_eligible,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_ptr_nxt
);

    logic          w_found;
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_sel;

    // Rotating first-eligible search starting at the priority pointer.
    always_comb begin
        o_grant   = '0;
        o_ptr_nxt = i_ptr;
        w_found   = 1'b0;
        w_sum     = '0;
        w_sel     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ))
                w_sum = w_sum - (PW+1)'(NREQ);
            w_sel = w_sum[PW-1:0];
            if (!w_found && i_eligible[w_sel]) begin
                w_found        = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_ptr_nxt      = (w_sel == PW'(NREQ - 1)) ? '0 : w_sel + PW'(1);
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: NREQ requesters share one registered 8x8 signed approximate
// multiplier. One grant per cycle, round-robin; each requester owns a single
// result slot. Optional error statistics against an exact product are built
// when MUL_ARB_ERRSTAT_EN is defined (adds outputs err_acc / err_cnt).
//
// slot state     | meaning
// SLOT_EMPTY     | no result held, requester may issue
// SLOT_INFLIGHT  | operands issued, product arrives next cycle
// SLOT_FULL      | rsp_data valid, held until rsp_ready
module mul_share_arb
    import mul_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int RR_EN_INIT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*OP_W-1:0]     req_a,
    input  logic [NREQ*OP_W-1:0]     req_b,
    output logic [OP_W-1:0]          mul_a,
    output logic [OP_W-1:0]          mul_b,
    input  logic [PROD_W-1:0]        mul_o,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [NREQ*PROD_W-1:0]   rsp_data
`ifdef MUL_ARB_ERRSTAT_EN
    ,
    output logic [31:0]              err_acc,
    output logic [15:0]              err_cnt
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    slot_state_e            r_state [0:NREQ-1];
    logic                   r_tag_vld;
    logic [PW-1:0]          r_tag_idx;
    logic [PW-1:0]          r_ptr;
    logic [NREQ*PROD_W-1:0] r_rsp_data;

    logic [NREQ-1:0]        w_elig;
    logic [NREQ-1:0]        w_grant;
    logic [PW-1:0]          w_ptr_nxt;
    logic [PW-1:0]          w_win_idx;
    logic                   w_any;

    // A slot can take new operands when empty, or when full and its result
    // leaves this same cycle. Reset masks all grants.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++)
            w_elig[i] = rst && req_valid[i] &&
                        ((r_state[i] == SLOT_EMPTY) ||
                         ((r_state[i] == SLOT_FULL) && rsp_ready[i]));
    end

    mul_arb_rr #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .i_eligible (w_elig),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_ptr_nxt  (w_ptr_nxt)
    );

    assign w_any     = |w_grant;
    assign req_ready = w_grant;
    assign rsp_data  = r_rsp_data;

    // Steer the winner's operands to the multiplier; zero when idle.
    always_comb begin
        w_win_idx = '0;
        mul_a     = '0;
        mul_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_win_idx = PW'(i);
                mul_a     = req_a[i*OP_W +: OP_W];
                mul_b     = req_b[i*OP_W +: OP_W];
            end
        end
    end

    // Result-valid follows the FULL state, forced low during reset.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++)
            rsp_valid[i] = rst && (r_state[i] == SLOT_FULL);
    end

    // Slot states, in-flight tag and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++)
                r_state[i] <= SLOT_EMPTY;
            r_tag_vld <= 1'b0;
            r_tag_idx <= '0;
            r_ptr     <= PW'(RR_EN_INIT);
        end else begin
            r_tag_vld <= w_any;
            r_tag_idx <= w_win_idx;
            if (w_any)
                r_ptr <= w_ptr_nxt;
            for (int i = 0; i < NREQ; i++) begin
                if (w_grant[i])
                    r_state[i] <= SLOT_INFLIGHT;
                else if (r_tag_vld && (r_tag_idx == PW'(i)))
                    r_state[i] <= SLOT_FULL;
                else if ((r_state[i] == SLOT_FULL) && rsp_ready[i])
                    r_state[i] <= SLOT_EMPTY;
            end
        end
    end

    // Capture the returning product into the slot named by the tag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rsp_data <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (r_tag_vld && (r_tag_idx == PW'(i)))
                    r_rsp_data[i*PROD_W +: PROD_W] <= mul_o;
        end
    end

`ifdef MUL_ARB_ERRSTAT_EN
    logic signed [PROD_W-1:0] r_exact;
    logic [31:0]              r_err_acc;
    logic [15:0]              r_err_cnt;
    logic signed [PROD_W+1:0] w_diff;
    logic [PROD_W:0]          w_abs;
    logic [32:0]              w_acc_sum;

    // Exact product delayed one cycle so it lines up with mul_o.
    always_ff @(posedge clk) begin
        if (!rst)
            r_exact <= '0;
        else
            r_exact <= $signed(mul_a) * $signed(mul_b);
    end

    // Absolute error; 18 bits covers exact minus any 16-bit mul_o.
    always_comb begin
        w_diff    = (PROD_W+2)'(r_exact) - (PROD_W+2)'($signed(mul_o));
        w_abs     = w_diff[PROD_W+1] ? (PROD_W+1)'(-w_diff) : (PROD_W+1)'(w_diff);
        w_acc_sum = {1'b0, r_err_acc} + {16'd0, w_abs};
    end

    // Saturating accumulation, only for products the tag marks as live.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_acc <= '0;
            r_err_cnt <= '0;
        end else if (r_tag_vld) begin
            r_err_acc <= w_acc_sum[32] ? 32'hFFFF_FFFF : w_acc_sum[31:0];
            if (r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_acc = r_err_acc;
    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: directed scenarios plus random traffic, checked
// against a cycle-count reference model and a per-requester result scoreboard.
module tb_mul_share_arb;

    localparam int NREQ = 4;
    localparam int RR_INIT = 0;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*8-1:0]  req_a, req_b;
    logic [7:0]      mul_a, mul_b;
    logic [15:0]     mul_o = '0;
    logic [NREQ*16-1:0] rsp_data;
`ifdef MUL_ARB_ERRSTAT_EN
    logic [31:0]     err_acc;
    logic [15:0]     err_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_share_arb #(.NREQ(NREQ), .RR_EN_INIT(RR_INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_o     (mul_o),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
`ifdef MUL_ARB_ERRSTAT_EN
        ,
        .err_acc   (err_acc),
        .err_cnt   (err_cnt)
`endif
    );

    // Approximate multiplier: exact product with two LSBs dropped, except a
    // fixed error case for the most-negative square.
    function automatic logic [15:0] approx_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        if (a == 8'h80 && b == 8'h80)
            return 16'd15625;
        p = $signed(a) * $signed(b);
        return 16'(p & ~3);
    endfunction

    always @(posedge clk) mul_o <= approx_mul(mul_a, mul_b);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] exp_q [NREQ][$];
    bit          outst [NREQ];
    int          iss   [NREQ];
    int          mptr = RR_INIT;
    int          cyc = 0;

    // Arbitration model: a requester with an outstanding result may reissue
    // only once its result has been visible (issue + 2) and is being taken.
    always @(negedge clk) begin
        logic [NREQ-1:0] eg, ev;
        logic [7:0]      ea, eb;
        int              g, idx;
        cyc++;
        if (!rst) begin
            chk("reset_outputs", {req_ready, rsp_valid, mul_a, mul_b}, '0);
            for (int i = 0; i < NREQ; i++) begin
                outst[i] = 1'b0;
                exp_q[i].delete();
            end
            mptr = RR_INIT;
        end else begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (mptr + k) % NREQ;
                if (g < 0 && req_valid[idx] &&
                    (!outst[idx] || (cyc >= iss[idx] + 2 && rsp_ready[idx])))
                    g = idx;
            end
            eg = '0;
            ea = '0;
            eb = '0;
            if (g >= 0) begin
                eg[g] = 1'b1;
                ea = req_a[g*8 +: 8];
                eb = req_b[g*8 +: 8];
            end
            chk("req_ready", req_ready, eg);
            chk("mul_ops", {mul_a, mul_b}, {ea, eb});
            ev = '0;
            for (int i = 0; i < NREQ; i++)
                ev[i] = outst[i] && (cyc >= iss[i] + 2);
            chk("rsp_valid", rsp_valid, ev);
            for (int i = 0; i < NREQ; i++)
                if (ev[i] && rsp_ready[i])
                    outst[i] = 1'b0;
            if (g >= 0) begin
                outst[g] = 1'b1;
                iss[g]   = cyc;
                exp_q[g].push_back(approx_mul(ea, eb));
                mptr = (g + 1) % NREQ;
            end
        end
    end

    // Result monitor: pops the scoreboard whenever the DUT hands over a result.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk("rsp_unexpected", {60'd0, 4'(i)}, 64'hFFFF);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk("rsp_data", rsp_data[i*16 +: 16], e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr);
        req_valid = v;
        rsp_ready = rr;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
        step();
        do_reset();
        @(negedge clk);
        chk("rsp_data_reset", rsp_data, '0);
        step();

`ifdef MUL_ARB_ERRSTAT_EN
        req_a[7:0] = 8'h80;
        req_b[7:0] = 8'h80;
        drv(4'b0001, 4'b1111);
        drv(4'b0000, 4'b1111);
        drv(4'b0000, 4'b1111);
        chk("err_acc", err_acc, 32'd759);
        chk("err_cnt", err_cnt, 16'd1);
        do_reset();
`endif

        // single request 3 x 5
        req_a[7:0] = 8'd3;
        req_b[7:0] = 8'd5;
        drv(4'b0001, 4'b1111);
        repeat (3) drv(4'b0000, 4'b1111);

        // all requesters continuously valid
        do_reset();
        for (int n = 0; n < 10; n++) begin
            req_a = $urandom;
            req_b = $urandom;
            drv(4'b1111, 4'b1111);
        end
        repeat (3) drv(4'b0000, 4'b1111);

        // requester 1 holds a FULL slot, then is re-granted on release
        do_reset();
        req_a = $urandom;
        req_b = $urandom;
        drv(4'b0010, 4'b0000);
        repeat (2) drv(4'b0000, 4'b0000);
        for (int n = 0; n < 6; n++) begin
            req_a = $urandom;
            req_b = $urandom;
            drv(4'b1111, 4'b1101);
        end
        drv(4'b0010, 4'b0010);
        repeat (3) drv(4'b0000, 4'b1111);

        // reset the cycle after granting requester 2
        do_reset();
        drv(4'b0100, 4'b1111);
        rst = 1'b0;
        drv(4'b0000, 4'b1111);
        rst = 1'b1;
        repeat (3) drv(4'b0000, 4'b1111);

        // pointer wrap: last winner 3, then 0 and 2 compete
        do_reset();
        drv(4'b1000, 4'b1111);
        drv(4'b0101, 4'b1111);
        repeat (3) drv(4'b0000, 4'b1111);

        // random traffic with occasional reset
        for (int n = 0; n < 1500; n++) begin
            req_a = $urandom;
            req_b = $urandom;
            rst = ($urandom_range(0, 99) != 0);
            drv(4'($urandom), 4'($urandom));
        end
        rst = 1'b1;
        repeat (4) drv(4'b0000, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
MUL_SHARE_ARB -- requirements
Module: mul_share_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one registered 8x8 signed approximate multiplier.
REQ-002 Parameter RR_EN_INIT, default 0: index of the requester that holds top priority after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  NREQ  per-requester operand-valid.
REQ-006 req_ready  output  NREQ  per-requester accept; a transfer occurs when valid and ready are both high.
REQ-007 req_a, req_b  input  NREQ*8 each  signed operands; requester i occupies bits [8i+7:8i].
REQ-008 mul_a, mul_b  output  8 each  operands driven to the shared multiplier.
REQ-009 mul_o  input  16  multiplier product, registered, valid exactly 1 cycle after operands are presented.
REQ-010 rsp_valid  output  NREQ  per-requester result-valid.
REQ-011 rsp_ready  input  NREQ  per-requester result-accept.
REQ-012 rsp_data  output  NREQ*16  per-requester result register; requester i occupies bits [16i+15:16i].

Function
REQ-013 Each requester owns one slot with states EMPTY, INFLIGHT and FULL.
REQ-014 A requester is eligible when req_valid is high and its slot is EMPTY, or its slot is FULL with rsp_ready high in the same cycle.
REQ-015 Exactly one eligible requester is granted per cycle, round-robin; priority starts at the index after the last winner.
REQ-016 req_ready is one-hot or zero and is high only for the granted requester, combinationally from current state and inputs.
REQ-017 On grant, mul_a/mul_b carry that requester's operands in the same cycle; with no grant, mul_a/mul_b are 0.
REQ-018 The granted slot goes to INFLIGHT; on the next edge mul_o is captured into that slot's rsp_data and the slot goes to FULL.
REQ-019 Issue-to-rsp_valid latency is 2 cycles; a new grant is allowed every cycle (throughput 1 product/cycle).
REQ-020 A FULL slot holds rsp_valid and rsp_data stable until rsp_ready is high; it then goes to EMPTY, or to INFLIGHT if re-granted in the same cycle.
REQ-021 A tag register holding the in-flight requester index and an in-flight flag routes mul_o; with no flag set, mul_o is ignored.
REQ-022 rsp_ready asserted on a slot that is not FULL has no effect.
REQ-023 The round-robin pointer wraps from NREQ-1 to 0 and is unchanged in a cycle with no grant.

Reset
REQ-024 While rst is low: all slots go to EMPTY, the in-flight flag clears, the pointer loads RR_EN_INIT, and req_ready, rsp_valid, mul_a and mul_b are 0.
REQ-025 rsp_data resets to 0.
REQ-026 Reset mid-operation discards any in-flight product; mul_o in the first cycle after rst rises is ignored.

Configuration
REQ-027 Macro MUL_ARB_ERRSTAT_EN: when defined, the block computes the exact product of each issued operand pair, delays it 1 cycle, and accumulates |exact - mul_o| into output err_acc (32 bits, saturating) and a count into output err_cnt (16 bits, saturating); both reset to 0.
REQ-028 When MUL_ARB_ERRSTAT_EN is undefined, err_acc and err_cnt are absent and no exact multiplier is synthesized.

Structure
REQ-029 Package mul_arb_pkg holds the slot-state enum (EMPTY/INFLIGHT/FULL), the operand width 8 and the product width 16.
REQ-030 Sub-module mul_arb_rr is the combinational round-robin picker: inputs eligible and pointer, outputs one-hot grant and next pointer.

Verification
REQ-031 Single request: after reset, req0 with a=3, b=5 -> req_ready[0]=1 in cycle 0, rsp_valid[0]=1 with rsp_data[0]=mul_o (model) in cycle 2.
REQ-032 All 4 requesters valid continuously with rsp_ready all 1 -> grants 0,1,2,3,0 on consecutive cycles and one product per cycle.
REQ-033 Requester 1 has a FULL slot with rsp_ready[1]=0 and req_valid[1]=1 -> never granted; other requesters are still served; on rsp_ready[1]=1, it is re-granted in the same cycle.
REQ-034 Reset asserted the cycle after a grant to requester 2 -> rsp_valid all 0, with no capture after reset release.
REQ-035 With MUL_ARB_ERRSTAT_EN defined, issue a=-128, b=-128 against a multiplier model returning 16384-759 -> err_acc=759 and err_cnt=1.
REQ-036 Pointer wrap: last winner 3, requesters 0 and 2 valid -> requester 0 is granted.
